// File: rtl/led_status_scheduler.sv
// Purpose : sequences the three status RGB LEDs from EU/CU/RU unit events with one
//           fault FSM per unit plus a global run FSM and a shared blink timer.
// Latency : an event sampled at edge N updates state at edge N; led_rgb follows at edge N+1.
// Backpressure: none; every input is a level or a 1-cycle pulse and is always accepted.
//
// Ports:
//   clk_50M       in   system clock
//   rst           in   synchronous active-high reset
//   switch_key    in   run enable level (low = LEDs dark, events ignored)
//   fault_flag    in   [2:0] per-unit pulse, fault raised   ([0]=EU [1]=CU [2]=RU)
//   fault_detect  in   [2:0] per-unit pulse, fault located
//   block_picked  in   [2:0] per-unit pulse, repair block picked
//   object_drop   in   [2:0] per-unit pulse, block dropped / fault cleared
//   run_complete  in   pulse, run finished
//   led_rgb       out  [8:0] {R,G,B} of LED i+1 on bits [3i+2:3i], registered
//   blink_phase   out  current blink phase, 1 = on half
//   run_state     out  [1:0] 0 IDLE, 1 RUN, 2 DONE_BLINK, 3 DONE
//
// Optional feature: define LED_PWM_DIM_EN to dim every lit LED bit with a 16-slot PWM
// (on while slot < DIM_DUTY). Without it the lit bits are steady and DIM_DUTY is unused.

module led_status_scheduler #(
  parameter int BLINK_HALF_CYCLES = 25_000_000,
  parameter int COMPLETE_BLINKS   = 5,
  parameter int DIM_DUTY          = 4
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       switch_key,
  input  logic [2:0] fault_flag,
  input  logic [2:0] fault_detect,
  input  logic [2:0] block_picked,
  input  logic [2:0] object_drop,
  input  logic       run_complete,
  output logic [8:0] led_rgb,
  output logic       blink_phase,
  output logic [1:0] run_state
);

  // Elaboration-time guard: the half-period counter needs at least two states.
  if (BLINK_HALF_CYCLES < 2 || COMPLETE_BLINKS < 1 || DIM_DUTY < 0 || DIM_DUTY > 16) begin : g_param_check
    $error("led_status_scheduler: illegal parameter value");
  end

  localparam int CW = $clog2(BLINK_HALF_CYCLES);
  localparam int FW = (COMPLETE_BLINKS > 1) ? $clog2(COMPLETE_BLINKS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(BLINK_HALF_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(COMPLETE_BLINKS - 1);

  // Encoding matches the run_state output values.
  typedef enum logic [1:0] {
    G_IDLE       = 2'd0,
    G_RUN        = 2'd1,
    G_DONE_BLINK = 2'd2,
    G_DONE       = 2'd3
  } run_t;

  typedef enum logic [2:0] {
    U_OFF,
    U_FAULT,
    U_DETECTED,
    U_PICKED,
    U_CLEARED
  } unit_t;

  run_t            state_q, state_d;
  unit_t           unit_q [3];
  unit_t           unit_d [3];
  logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic [FW-1:0]   flash_q, flash_d;
  logic [8:0]      led_d;
  logic [8:0]      led_gated;

  logic            wrap;
  logic            done_exit;
  logic            unit_en;
  logic            enter_blink;
  logic            clear_units;
  logic            timer_run;

  assign wrap      = (blink_cnt_q == CNT_LAST);
  // The last off half ends exactly when the phase is about to go 0 -> 1 for the final time.
  assign done_exit = wrap && !phase_q && (flash_q == FLASH_LAST);
  assign timer_run = (state_q == G_RUN) || (state_q == G_DONE_BLINK);

  function automatic logic [2:0] unit_colour(unit_t s, logic ph);
    logic [2:0] c;
    c = 3'b000;
    case (s)
      U_FAULT:    c = 3'b100;
      U_DETECTED: c = 3'b001;
      U_PICKED:   c = ph ? 3'b001 : 3'b000;
      U_CLEARED:  c = 3'b010;
      default:    c = 3'b000;
    endcase
    return c;
  endfunction

  // Global FSM next state. switch_key low wins over everything; run_complete wins
  // over unit events in the same cycle, so those events are dropped.
  always_comb begin
    state_d     = state_q;
    unit_en     = 1'b0;
    enter_blink = 1'b0;
    clear_units = 1'b0;
    case (state_q)
      G_IDLE: begin
        if (switch_key) state_d = G_RUN;
      end
      G_RUN: begin
        if (!switch_key) begin
          state_d = G_IDLE;
        end else if (run_complete) begin
          state_d     = G_DONE_BLINK;
          enter_blink = 1'b1;
        end else begin
          unit_en = 1'b1;
        end
      end
      G_DONE_BLINK: begin
        if (!switch_key) begin
          state_d = G_IDLE;
        end else if (done_exit) begin
          state_d     = G_DONE;
          clear_units = 1'b1;
        end
      end
      G_DONE: begin
        state_d = G_DONE;
      end
      default: state_d = G_IDLE;
    endcase
  end

  // Per-unit FSMs. Only the transition legal from the current state can fire, so
  // simultaneous unrelated pulses are ignored automatically.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      unit_d[i] = unit_q[i];
      if (clear_units) begin
        unit_d[i] = U_OFF;
      end else if (unit_en) begin
        case (unit_q[i])
          U_OFF, U_CLEARED: if (fault_flag[i])   unit_d[i] = U_FAULT;
          U_FAULT:          if (fault_detect[i]) unit_d[i] = U_DETECTED;
          U_DETECTED:       if (block_picked[i]) unit_d[i] = U_PICKED;
          U_PICKED:         if (object_drop[i])  unit_d[i] = U_CLEARED;
          default:          unit_d[i] = U_OFF;
        endcase
      end
    end
  end

  // Blink timer and flash counter. Entering DONE_BLINK restarts both so the
  // completion pattern always begins with a full on half.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    flash_d     = flash_q;
    if (enter_blink || !timer_run) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (wrap) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    if (enter_blink) begin
      flash_d = '0;
    end else if (state_q == G_DONE_BLINK && wrap && !phase_q && flash_q != FLASH_LAST) begin
      flash_d = flash_q + 1'b1;
    end
  end

  // LED colour from the current registered state; registered once more below.
  always_comb begin
    led_d = '0;
    case (state_q)
      G_RUN: begin
        for (int i = 0; i < 3; i++) begin
          led_d[3*i +: 3] = unit_colour(unit_q[i], phase_q);
        end
      end
      G_DONE_BLINK: begin
        if (phase_q) led_d = {3{3'b010}};
      end
      default: led_d = '0;
    endcase
  end

`ifdef LED_PWM_DIM_EN
  logic [3:0] pwm_slot_q;
  logic       pwm_on;

  always_ff @(posedge clk_50M) begin
    if (rst) pwm_slot_q <= '0;
    else     pwm_slot_q <= pwm_slot_q + 1'b1;
  end

  assign pwm_on    = ({1'b0, pwm_slot_q} < 5'(DIM_DUTY));
  assign led_gated = led_d & {9{pwm_on}};
`else
  assign led_gated = led_d;
`endif

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q     <= G_IDLE;
      for (int i = 0; i < 3; i++) unit_q[i] <= U_OFF;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      flash_q     <= '0;
      led_rgb     <= '0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < 3; i++) unit_q[i] <= unit_d[i];
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      flash_q     <= flash_d;
      led_rgb     <= led_gated;
    end
  end

  assign blink_phase = phase_q;
  assign run_state   = state_q;

endmodule

// File: tb/tb_led_status_scheduler.sv
// Purpose : self-checking bench for led_status_scheduler (directed steps, then random events)
// Latency : compares every cycle, half a clock after the active edge
// Backpressure: n/a
module tb_led_status_scheduler;

  localparam int HALF = 4;
  localparam int NBL  = 2;
  localparam int DUTY = 4;

  logic       clk_50M = 1'b0;
  logic       rst = 1'b1;
  logic       switch_key = 1'b0;
  logic [2:0] fault_flag = '0;
  logic [2:0] fault_detect = '0;
  logic [2:0] block_picked = '0;
  logic [2:0] object_drop = '0;
  logic       run_complete = 1'b0;
  logic [8:0] led_rgb;
  logic       blink_phase;
  logic [1:0] run_state;

  int checks = 0;
  int errors = 0;

  // Reference model: global state 0..3, unit state 0 OFF 1 FAULT 2 DETECTED
  // 3 PICKED 4 CLEARED, timer expressed as an age in cycles since it last restarted.
  int         m_gs;
  int         m_u [3];
  int         m_age;
  int         m_slot;
  logic [8:0] m_led;

  always #5 clk_50M = ~clk_50M;

  led_status_scheduler #(
    .BLINK_HALF_CYCLES(HALF),
    .COMPLETE_BLINKS  (NBL),
    .DIM_DUTY         (DUTY)
  ) dut (
    .clk_50M      (clk_50M),
    .rst          (rst),
    .switch_key   (switch_key),
    .fault_flag   (fault_flag),
    .fault_detect (fault_detect),
    .block_picked (block_picked),
    .object_drop  (object_drop),
    .run_complete (run_complete),
    .led_rgb      (led_rgb),
    .blink_phase  (blink_phase),
    .run_state    (run_state)
  );

  function automatic logic m_phase(int age);
    return ((age / HALF) % 2) == 0;
  endfunction

  task automatic model_step();
    logic [8:0] nl;
    logic       ph;
    ph = m_phase(m_age);
    nl = '0;
    if (m_gs == 1) begin
      for (int i = 0; i < 3; i++) begin
        case (m_u[i])
          1: nl[3*i +: 3] = 3'b100;
          2: nl[3*i +: 3] = 3'b001;
          3: nl[3*i +: 3] = ph ? 3'b001 : 3'b000;
          4: nl[3*i +: 3] = 3'b010;
          default: nl[3*i +: 3] = 3'b000;
        endcase
      end
    end else if (m_gs == 2 && ph) begin
      nl = 9'b010_010_010;
    end
`ifdef LED_PWM_DIM_EN
    if (m_slot >= DUTY) nl = '0;
`endif
    if (rst) begin
      m_gs = 0;
      for (int i = 0; i < 3; i++) m_u[i] = 0;
      m_age  = 0;
      m_slot = 0;
      m_led  = '0;
      return;
    end
    m_led  = nl;
    m_slot = (m_slot + 1) % 16;
    case (m_gs)
      0: begin
        m_age = 0;
        if (switch_key) m_gs = 1;
      end
      1: begin
        if (!switch_key) begin
          m_gs = 0;
          m_age++;
        end else if (run_complete) begin
          m_gs  = 2;
          m_age = 0;
        end else begin
          m_age++;
          for (int i = 0; i < 3; i++) begin
            case (m_u[i])
              0, 4: if (fault_flag[i])   m_u[i] = 1;
              1:    if (fault_detect[i]) m_u[i] = 2;
              2:    if (block_picked[i]) m_u[i] = 3;
              3:    if (object_drop[i])  m_u[i] = 4;
              default: ;
            endcase
          end
        end
      end
      2: begin
        m_age++;
        if (!switch_key) begin
          m_gs = 0;
        end else if (m_age == 2 * HALF * NBL) begin
          m_gs = 3;
          for (int i = 0; i < 3; i++) m_u[i] = 0;
        end
      end
      default: m_age = 0;
    endcase
  endtask

  task automatic compare_all(string tag);
    logic       exp_ph;
    logic [1:0] exp_st;
    exp_ph = m_phase(m_age);
    exp_st = 2'(m_gs);
    checks++;
    assert (led_rgb === m_led) else begin
      errors++;
      $error("FAIL %s led_rgb got %b want %b", tag, led_rgb, m_led);
    end
    checks++;
    assert (blink_phase === exp_ph) else begin
      errors++;
      $error("FAIL %s blink_phase got %b want %b", tag, blink_phase, exp_ph);
    end
    checks++;
    assert (run_state === exp_st) else begin
      errors++;
      $error("FAIL %s run_state got %0d want %0d", tag, run_state, exp_st);
    end
  endtask

  task automatic tick(string tag);
    @(posedge clk_50M);
    model_step();
    @(negedge clk_50M);
    compare_all(tag);
  endtask

  task automatic check_val(string tag, logic [8:0] act, logic [8:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s got %b want %b", tag, act, exp);
    end
  endtask

  function automatic logic [2:0] rnd3();
    logic [2:0] r;
    for (int b = 0; b < 3; b++) r[b] = ($urandom_range(0, 4) == 0);
    return r;
  endfunction

  initial begin
    m_gs = 0; m_age = 0; m_slot = 0; m_led = '0;
    for (int i = 0; i < 3; i++) m_u[i] = 0;

    // Reset state
    @(negedge clk_50M);
    tick("reset0");
    tick("reset1");
    check_val("reset_led", led_rgb, 9'd0);
    check_val("reset_phase", {8'd0, blink_phase}, 9'd1);
    check_val("reset_state", {7'd0, run_state}, 9'd0);
    rst = 1'b0;

    // Enter RUN
    switch_key = 1'b1;
    tick("enter_run");
    check_val("run_state_run", {7'd0, run_state}, 9'd1);

    // EU fault: red two edges after the pulse, other LEDs dark
    fault_flag = 3'b001; tick("eu_fault");
    fault_flag = 3'b000; tick("eu_fault_led");
`ifndef LED_PWM_DIM_EN
    check_val("eu_red", led_rgb, 9'b000_000_100);
`endif
    fault_detect = 3'b001; tick("eu_detect");
    fault_detect = 3'b000; tick("eu_detect_led");
`ifndef LED_PWM_DIM_EN
    check_val("eu_blue", led_rgb, 9'b000_000_001);
`endif
    block_picked = 3'b001; tick("eu_pick");
    block_picked = 3'b000;
    for (int k = 0; k < 12; k++) tick("eu_pick_blink");
    object_drop = 3'b001; tick("eu_drop");
    object_drop = 3'b000; tick("eu_drop_led");
`ifndef LED_PWM_DIM_EN
    check_val("eu_green", led_rgb, 9'b000_000_010);
`else
    begin
      int highs;
      highs = 0;
      for (int k = 0; k < 16; k++) begin
        tick("pwm_window");
        if (led_rgb[1]) highs++;
      end
      check_val("pwm_duty", 9'(highs), 9'(DUTY));
    end
`endif

    // CU reaches DETECTED, then out-of-order pulses must not move it
    fault_flag = 3'b010; tick("cu_fault");
    fault_flag = 3'b000; fault_detect = 3'b010; tick("cu_detect");
    fault_detect = 3'b000; tick("cu_idle");
    object_drop = 3'b010; fault_flag = 3'b010; tick("cu_illegal");
    object_drop = 3'b000; fault_flag = 3'b000; tick("cu_illegal_led");
`ifndef LED_PWM_DIM_EN
    check_val("cu_still_blue", led_rgb, 9'b000_001_010);
`endif
    block_picked = 3'b010; tick("cu_pick");
    block_picked = 3'b000;
    for (int k = 0; k < 6; k++) tick("cu_pick_blink");

    // Pause and resume keeps unit states
    switch_key = 1'b0; tick("pause0"); tick("pause1");
    check_val("pause_led", led_rgb, 9'd0);
    check_val("pause_state", {7'd0, run_state}, 9'd0);
    for (int k = 0; k < 3; k++) tick("paused");
    switch_key = 1'b1;
    for (int k = 0; k < 8; k++) tick("resume");

    // Completion blink then DONE
    run_complete = 1'b1; fault_flag = 3'b100; tick("run_complete");
    run_complete = 1'b0; fault_flag = 3'b000;
    check_val("done_blink_state", {7'd0, run_state}, 9'd2);
    for (int k = 0; k < 20; k++) tick("done_blink");
    check_val("done_state", {7'd0, run_state}, 9'd3);
    check_val("done_led", led_rgb, 9'd0);
    fault_flag = 3'b111; tick("done_sticky");
    fault_flag = 3'b000; tick("done_sticky2");

    // Reset in the middle of the completion blink
    rst = 1'b1; tick("rst2");
    rst = 1'b0; tick("rerun");
    run_complete = 1'b1; tick("rc2");
    run_complete = 1'b0;
    for (int k = 0; k < 5; k++) tick("blink2");
    rst = 1'b1; tick("rst_mid_blink");
    check_val("rst_mid_led", led_rgb, 9'd0);
    check_val("rst_mid_state", {7'd0, run_state}, 9'd0);
    check_val("rst_mid_phase", {8'd0, blink_phase}, 9'd1);
    rst = 1'b0;

    // Random traffic against the model
    switch_key = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      rst          = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 59) == 0) switch_key = ~switch_key;
      fault_flag   = rnd3();
      fault_detect = rnd3();
      block_picked = rnd3();
      object_drop  = rnd3();
      run_complete = ($urandom_range(0, 119) == 0);
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
